fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO used in the AHB-to-APB bridge. It is the write-domain counterpart of the read-side controller. It keeps the binary write pointer, drives the dual-port memory write address and enable, and publishes a registered Gray-coded write pointer for synchronisation into the read domain. It also compares against the synchronised Gray read pointer to produce full, almost-full, fill-level and a sticky overflow flag.

---
 rtl/fifo_wr_ctrl_if.sv | 26 ++
 rtl/fifo_wr_ctrl.sv | 62 ++++++
 tb/tb_fifo_wr_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ctrl_if.sv
// rtl/fifo_wr_ctrl_if.sv - write-side FIFO controller signal bundle
// Producer (master) and controller (slave) views of the write-domain signals.
interface fifo_wr_ctrl_if #(
  parameter int P_SIZE = 4
);
  logic              w_inc;
  logic              ovf_clr;
  logic [P_SIZE-1:0] sync_rd_ptr;
  logic [P_SIZE-2:0] w_addr;
  logic              w_en;
  logic              full;
  logic              almost_full;
  logic [P_SIZE-1:0] wr_level;
  logic              overflow;
  logic [P_SIZE-1:0] gray_wr_ptr;

  modport master (
    output w_inc, ovf_clr, sync_rd_ptr,
    input  w_addr, w_en, full, almost_full, wr_level, overflow, gray_wr_ptr
  );

  modport slave (
    input  w_inc, ovf_clr, sync_rd_ptr,
    output w_addr, w_en, full, almost_full, wr_level, overflow, gray_wr_ptr
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write pointer, full/level flags and sticky overflow
// Full/level compare against the already-synchronised Gray read pointer, so they are pessimistic.
module fifo_wr_ctrl #(
  parameter int P_SIZE    = 4,
  parameter int AF_THRESH = 6
) (
  input  logic          w_clk,
  input  logic          w_rstn,
  fifo_wr_ctrl_if.slave bus
);
  localparam logic [P_SIZE-1:0] AF_LVL = P_SIZE'(AF_THRESH);

  logic [P_SIZE-1:0] wr_ptr;
  logic [P_SIZE-1:0] wr_gray_c;
  logic [P_SIZE-1:0] rd_bin;
  logic [P_SIZE-1:0] full_cmp;
  logic [P_SIZE-1:0] gray_q;
  logic              overflow_q;
  logic              full_c;
  logic              w_en_c;

  assign wr_gray_c = wr_ptr ^ (wr_ptr >> 1);

  // Full when the pointers differ only in the two MSBs of their Gray codes.
  assign full_cmp = {~bus.sync_rd_ptr[P_SIZE-1:P_SIZE-2], bus.sync_rd_ptr[P_SIZE-3:0]};
  assign full_c   = (wr_gray_c == full_cmp);
  assign w_en_c   = bus.w_inc & ~full_c;

  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < P_SIZE; i++) begin
      rd_bin[i] = ^(bus.sync_rd_ptr >> i);
    end
  end

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      wr_ptr     <= '0;
      gray_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_en_c) begin
        wr_ptr <= wr_ptr + P_SIZE'(1);
      end
      gray_q <= wr_gray_c;
      // A write attempt against a full FIFO outranks a simultaneous clear.
      if (bus.w_inc && full_c) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.w_addr      = wr_ptr[P_SIZE-2:0];
  assign bus.w_en        = w_en_c;
  assign bus.full        = full_c;
  assign bus.wr_level    = wr_ptr - rd_bin;
  assign bus.almost_full = (bus.wr_level >= AF_LVL);
  assign bus.overflow    = overflow_q;
  assign bus.gray_wr_ptr = gray_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - scoreboard bench for fifo_wr_ctrl
// Accepted-write addresses are queued by the model and popped when the DUT raises w_en.
module tb_fifo_wr_ctrl;
  localparam int P = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.P_SIZE(P)) bus ();
  fifo_wr_ctrl #(.P_SIZE(P), .AF_THRESH(6)) dut (.w_clk(clk), .w_rstn(rstn), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;

  logic [3:0] m_ptr;
  logic [3:0] m_gray;
  logic       m_ovf;
  logic [2:0] addr_q[$];

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] m_level(input logic [3:0] rdg);
    logic [3:0] rb;
    rb[3] = rdg[3];
    for (int i = 2; i >= 0; i--) rb[i] = rb[i+1] ^ rdg[i];
    return m_ptr - rb;
  endfunction

  task automatic model_reset();
    m_ptr  = '0;
    m_gray = '0;
    m_ovf  = 1'b0;
    addr_q.delete();
  endtask

  task automatic step(input logic inc, input logic clr, input logic [3:0] rdg);
    logic       acc;
    logic       was_full;
    logic [2:0] exp_addr;
    bus.w_inc = inc; bus.ovf_clr = clr; bus.sync_rd_ptr = rdg;
    #1;
    was_full = (m_level(rdg) == 4'd8);
    acc = inc && !was_full;
    if (acc) addr_q.push_back(m_ptr[2:0]);
    vectors++; if (bus.w_en !== acc) begin miscompares++; $display("FAIL step_w_en: got %b want %b", bus.w_en, acc); end
    vectors++; if (bus.wr_level !== m_level(rdg)) begin miscompares++; $display("FAIL step_level: got %0d want %0d", bus.wr_level, m_level(rdg)); end
    vectors++; if (bus.gray_wr_ptr !== m_gray) begin miscompares++; $display("FAIL step_gray: got %b want %b", bus.gray_wr_ptr, m_gray); end
    vectors++; if (bus.overflow !== m_ovf) begin miscompares++; $display("FAIL step_ovf: got %b want %b", bus.overflow, m_ovf); end
    if (bus.w_en === 1'b1) begin
      accepted++;
      vectors++;
      if (addr_q.size() == 0) begin
        miscompares++; $display("FAIL sb_addr: got w_en with addr %0d want no write", bus.w_addr);
      end else begin
        exp_addr = addr_q.pop_front();
        if (bus.w_addr !== exp_addr) begin miscompares++; $display("FAIL sb_addr: got %0d want %0d", bus.w_addr, exp_addr); end
      end
    end
    @(posedge clk);
    m_gray = to_gray(m_ptr);
    if (inc && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (acc) m_ptr = m_ptr + 4'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.w_inc = 1'b0; bus.ovf_clr = 1'b0; bus.sync_rd_ptr = 4'd0;
    #3;
    vectors++; if (bus.w_addr !== 3'd0) begin miscompares++; $display("FAIL rst_addr: got %0d want 0", bus.w_addr); end
    vectors++; if (bus.gray_wr_ptr !== 4'd0) begin miscompares++; $display("FAIL rst_gray: got %b want 0000", bus.gray_wr_ptr); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b want 0", bus.full); end
    vectors++; if (bus.almost_full !== 1'b0) begin miscompares++; $display("FAIL rst_af: got %b want 0", bus.almost_full); end
    vectors++; if (bus.wr_level !== 4'd0) begin miscompares++; $display("FAIL rst_level: got %0d want 0", bus.wr_level); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b want 0", bus.overflow); end
    vectors++; if (bus.w_en !== 1'b0) begin miscompares++; $display("FAIL rst_w_en: got %b want 0", bus.w_en); end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'd0);
      if (i == 5) begin
        vectors++; if (bus.wr_level !== 4'd6) begin miscompares++; $display("FAIL fill6_level: got %0d want 6", bus.wr_level); end
        vectors++; if (bus.almost_full !== 1'b1) begin miscompares++; $display("FAIL fill6_af: got %b want 1", bus.almost_full); end
      end
    end
    vectors++; if (bus.wr_level !== 4'd8) begin miscompares++; $display("FAIL fill8_level: got %0d want 8", bus.wr_level); end
    vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("FAIL fill8_full: got %b want 1", bus.full); end
    vectors++; if (bus.w_en !== 1'b0) begin miscompares++; $display("FAIL fill8_w_en: got %b want 0", bus.w_en); end
    vectors++; if (bus.gray_wr_ptr !== 4'b0100) begin miscompares++; $display("FAIL fill8_gray: got %b want 0100", bus.gray_wr_ptr); end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 4'd0);
    vectors++; if (bus.gray_wr_ptr !== 4'b1100) begin miscompares++; $display("FAIL ovf_gray: got %b want 1100", bus.gray_wr_ptr); end
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
    vectors++; if (bus.w_addr !== 3'd0) begin miscompares++; $display("FAIL ovf_addr: got %0d want 0", bus.w_addr); end
    vectors++; if (bus.wr_level !== 4'd8) begin miscompares++; $display("FAIL ovf_level: got %0d want 8", bus.wr_level); end
    step(1'b1, 1'b1, 4'd0);
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b want 1", bus.overflow); end
    step(1'b0, 1'b1, 4'd0);
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b want 0", bus.overflow); end
  endtask

  task automatic test_read_free();
    bus.w_inc = 1'b1; bus.sync_rd_ptr = 4'b0010;
    #1;
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL rf_full: got %b want 0", bus.full); end
    vectors++; if (bus.wr_level !== 4'd5) begin miscompares++; $display("FAIL rf_level: got %0d want 5", bus.wr_level); end
    vectors++; if (bus.almost_full !== 1'b0) begin miscompares++; $display("FAIL rf_af: got %b want 0", bus.almost_full); end
    vectors++; if (bus.w_en !== 1'b1) begin miscompares++; $display("FAIL rf_w_en: got %b want 1", bus.w_en); end
    vectors++; if (bus.w_addr !== 3'd0) begin miscompares++; $display("FAIL rf_addr: got %0d want 0", bus.w_addr); end
    step(1'b1, 1'b0, 4'b0010);
    vectors++; if (bus.almost_full !== 1'b1) begin miscompares++; $display("FAIL rf_af6: got %b want 1", bus.almost_full); end
  endtask

  task automatic test_back_to_back();
    int         acc0;
    int         dut_wraps;
    int         m_wraps;
    logic [3:0] prev;
    logic [3:0] cur;
    acc0 = accepted; dut_wraps = 0; m_wraps = 0;
    prev = bus.gray_wr_ptr;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, to_gray(m_ptr - 4'd2));
      if (m_ptr == 4'd0) m_wraps++;
      cur = bus.gray_wr_ptr;
      vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL b2b_full[%0d]: got %b want 0", i, bus.full); end
      vectors++; if ($countones(cur ^ prev) != 1) begin miscompares++; $display("FAIL b2b_gray_step[%0d]: got %b->%b want one bit change", i, prev, cur); end
      if (prev == 4'b1000 && cur == 4'b0000) dut_wraps++;
      prev = cur;
    end
    vectors++; if (dut_wraps != m_wraps) begin miscompares++; $display("FAIL b2b_wraps: got %0d want %0d", dut_wraps, m_wraps); end
    vectors++; if (accepted - acc0 != 40) begin miscompares++; $display("FAIL b2b_accepted: got %0d want 40", accepted - acc0); end
    vectors++; if (addr_q.size() != 0) begin miscompares++; $display("FAIL b2b_lost: got %0d pending want 0", addr_q.size()); end
  endtask

  task automatic test_reset_mid();
    rstn = 1'b0; #2;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0);
    bus.w_inc = 1'b0;
    #2 rstn = 1'b0;
    #1;
    vectors++; if (bus.gray_wr_ptr !== 4'd0) begin miscompares++; $display("FAIL mid_gray: got %b want 0000", bus.gray_wr_ptr); end
    vectors++; if (bus.w_addr !== 3'd0) begin miscompares++; $display("FAIL mid_addr: got %0d want 0", bus.w_addr); end
    vectors++; if (bus.wr_level !== 4'd0) begin miscompares++; $display("FAIL mid_level: got %0d want 0", bus.wr_level); end
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL mid_ovf: got %b want 0", bus.overflow); end
    vectors++; if (bus.w_en !== 1'b0) begin miscompares++; $display("FAIL mid_w_en: got %b want 0", bus.w_en); end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    bus.w_inc = 1'b1;
    #1;
    vectors++; if (bus.w_addr !== 3'd0) begin miscompares++; $display("FAIL mid_first_addr: got %0d want 0", bus.w_addr); end
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    vectors++; if (bus.w_addr !== 3'd2) begin miscompares++; $display("FAIL mid_after_addr: got %0d want 2", bus.w_addr); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.w_inc = 1'b0; bus.ovf_clr = 1'b0; bus.sync_rd_ptr = 4'd0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_read_free();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
